// File: rtl/fifo_reader_pkg.sv
// Shared types and defaults for the FIFO read-side stream controller.
//
// Contents:
//   DefaultDataW : default FIFO / stream data width
//   state_e      : controller FSM states (idle, running, draining)
package fifo_reader_pkg;

  localparam int unsigned DefaultDataW = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } state_e;

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry skid buffer between the FIFO read port and the output stream.
//
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   push_i       : write push_data_i at the tail this edge
//   push_data_i  : data to write
//   pop_i        : retire the head entry this edge
//   occ_o        : number of stored entries, 0..2
//   head_valid_o : at least one entry is stored
//   head_data_o  : data of the head entry (zero after reset)
//
// Push and pop may happen on the same edge; occupancy is then unchanged and the
// head advances. The caller's credit logic keeps pushes away from a full buffer;
// the local guards only stop a stray strobe from corrupting the pointers.
module fifo_reader_skid
  import fifo_reader_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [1:0]        occ_o,
  output logic              head_valid_o,
  output logic [DATA_W-1:0] head_data_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        occ_q, occ_d;
  logic              pop_ok, push_ok;

  // A pop needs something stored; a push into a full buffer is only safe when
  // the head leaves on the same edge.
  assign pop_ok  = pop_i && (occ_q != 2'd0);
  assign push_ok = push_i && ((occ_q != 2'd2) || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;

    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = ~wr_ptr_q;
    end

    if (pop_ok) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    case ({push_ok, pop_ok})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign occ_o        = occ_q;
  assign head_valid_o = (occ_q != 2'd0);
  assign head_data_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side controller for the synchronous FIFO: issues read strobes while the
// FIFO is non-empty and there is room downstream, captures the read data one
// cycle later into a 2-entry skid buffer, and presents it as a valid/ready
// stream with a burst-end marker every BURST_LEN beats.
//
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   enable      : 1 = pull from the FIFO, 0 = stop reading and drain
//   fifo_empty  : FIFO empty flag
//   fifo_rd_en  : FIFO read strobe (combinational)
//   fifo_data   : FIFO read data, valid the cycle after fifo_rd_en
//   m_valid     : output beat valid
//   m_ready     : downstream accepts the beat
//   m_data      : output beat data
//   m_last      : final beat of a burst
//   busy        : controller is not idle
//   beat_cnt    : total beats delivered, wraps
module fifo_stream_reader
  import fifo_reader_pkg::*;
#(
  parameter int unsigned DATA_W    = DefaultDataW,
  parameter int unsigned BURST_LEN = 4,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic [CNT_W-1:0]  beat_cnt
);

  // A one-beat burst still needs a 1-bit position register.
  localparam int unsigned    BposW   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BposW-1:0] BposMax = BposW'(BURST_LEN - 1);

  state_e             state_q, state_d;
  logic               inflight_q;
  logic [BposW-1:0]   bpos_q, bpos_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

  logic [1:0]         occ;
  logic               pop;
  logic [2:0]         committed;
  logic               credit_ok;

  // ---------------------------------------------------------------------------
  // Skid buffer: written by the returning read, drained by the stream.
  // ---------------------------------------------------------------------------
  fifo_reader_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (inflight_q),
    .push_data_i  (fifo_data),
    .pop_i        (pop),
    .occ_o        (occ),
    .head_valid_o (m_valid),
    .head_data_o  (m_data)
  );

  assign pop = m_valid && m_ready;

  // ---------------------------------------------------------------------------
  // Credit: slots already spoken for after this edge (stored + returning - leaving).
  // A new read is allowed only while that stays below the buffer depth, so the
  // strobe drops in the very cycle the last slot gets claimed.
  // ---------------------------------------------------------------------------
  always_comb begin
    committed = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
    credit_ok = (committed < 3'd2);
  end

  // Enable gates the strobe directly so reads stop in the cycle it falls, not
  // one cycle later when the state register catches up. Reset also blocks it
  // so no byte is pulled out of the FIFO only to be thrown away.
  assign fifo_rd_en = rst_n && enable && (state_q == StRun) && !fifo_empty && credit_ok;

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (enable) state_d = StRun;
      end
      StRun: begin
        if (!enable) state_d = StDrain;
      end
      StDrain: begin
        if (enable) begin
          state_d = StRun;
        end else if ((occ == 2'd0) && !inflight_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Burst position and delivered-beat counter, both advanced per accepted beat.
  // ---------------------------------------------------------------------------
  always_comb begin
    bpos_d     = bpos_q;
    beat_cnt_d = beat_cnt_q;
    if (pop) begin
      bpos_d     = (bpos_q == BposMax) ? '0 : bpos_q + BposW'(1);
      beat_cnt_d = beat_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      inflight_q <= 1'b0;
      bpos_q     <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= fifo_rd_en;
      bpos_q     <= bpos_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign m_last   = (bpos_q == BposMax) && m_valid;
  assign busy     = (state_q != StIdle);
  assign beat_cnt = beat_cnt_q;

endmodule
